dafx_adc_frame_router: RTL and testbench

Parametrised successor of the fixed two-channel ADC deinterleave and IRQ logic in the DAFX core. It accepts an N-slot interleaved ADC sample stream and realigns it on the frame boundary. It publishes all channels atomically to the mixer with a single fs_strobe, tracks per-channel signed peak min/max, and generates M programmable periodic interrupts. It sits between the CS5343 ADC interface and mixer_top, with control and status registers driven from the DAFX AXI slave.

---
 rtl/dafx_adc_frame_router_if.sv | 13 +
 rtl/dafx_adc_frame_router.sv | 198 +++++++++++++++++++
 tb/tb_dafx_adc_frame_router.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dafx_adc_frame_router_if.sv
// ADC sample stream between the CS5343 interface and the frame router.
// The source drives data/valid/last; the router answers with ready.
interface dafx_adc_frame_router_if #(
  parameter int AUDIO_WIDTH_P = 24
);
  logic [AUDIO_WIDTH_P-1:0] adc_data;
  logic                     adc_valid;
  logic                     adc_ready;
  logic                     adc_last;

  modport master (output adc_data, output adc_valid, output adc_last, input adc_ready);
  modport slave  (input adc_data, input adc_valid, input adc_last, output adc_ready);
endinterface

// File: rtl/dafx_adc_frame_router.sv
// Realigns an N-slot interleaved ADC stream on the frame boundary, publishes
// every channel at once with fs_strobe, tracks signed per-channel peaks and
// runs NR_OF_IRQ_P periodic interrupt timers.
//
// state     | meaning
// ----------+------------------------------------------------------------
// SLOT_FILL | collecting beats into shadow[slot], commit on a proper last
// RESYNC    | frame was too long; drop beats until the next adc_last
module dafx_adc_frame_router #(
  parameter int AUDIO_WIDTH_P     = 24,
  parameter int NR_OF_SLOTS_P     = 2,
  parameter int SLOT_CNT_WIDTH_P  = $clog2(NR_OF_SLOTS_P + 1),
  parameter int NR_OF_IRQ_P       = 2,
  parameter int IRQ_CNT_WIDTH_P   = 32,
  parameter int FRAME_CNT_WIDTH_P = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  dafx_adc_frame_router_if.slave                   adc,
  input  logic                                     cr_enable,
  input  logic [NR_OF_IRQ_P*IRQ_CNT_WIDTH_P-1:0]   cr_irq_period,
  input  logic                                     cmd_clear_peak,
  input  logic                                     cmd_clear_err,
  output logic [NR_OF_SLOTS_P*AUDIO_WIDTH_P-1:0]   ch_data,
  output logic                                     fs_strobe,
  output logic [NR_OF_IRQ_P-1:0]                   irq,
  output logic [NR_OF_SLOTS_P*AUDIO_WIDTH_P-1:0]   sr_peak_max,
  output logic [NR_OF_SLOTS_P*AUDIO_WIDTH_P-1:0]   sr_peak_min,
  output logic                                     sr_frame_err,
  output logic [FRAME_CNT_WIDTH_P-1:0]             sr_frame_count
);

  localparam int AW = AUDIO_WIDTH_P;
  localparam int N  = NR_OF_SLOTS_P;
  localparam int IW = IRQ_CNT_WIDTH_P;
  localparam logic [SLOT_CNT_WIDTH_P-1:0] LAST_SLOT = SLOT_CNT_WIDTH_P'(N - 1);
  localparam logic [AW-1:0] MOST_NEG = {1'b1, {(AW-1){1'b0}}};
  localparam logic [AW-1:0] MOST_POS = {1'b0, {(AW-1){1'b1}}};

  typedef enum logic {SLOT_FILL, RESYNC} state_t;

  state_t                      state_q, state_d;
  logic [SLOT_CNT_WIDTH_P-1:0] slot_q, slot_d;
  logic                        ready_q;
  logic                        accept;
  logic                        at_last_slot;
  logic                        shadow_we;
  logic                        commit;
  logic                        frame_err_set;
  logic [AW-1:0]               shadow [N];
  logic [N*AW-1:0]             commit_frame;
  logic [IW-1:0]               period_q  [NR_OF_IRQ_P];
  logic [IW-1:0]               irq_cnt_q [NR_OF_IRQ_P];

  assign adc.adc_ready = ready_q;
  assign accept        = adc.adc_valid && ready_q;
  assign at_last_slot  = (slot_q == LAST_SLOT);

  // ready follows cr_enable one cycle late so the source sees a clean register
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= cr_enable;
  end

  // framing state and slot pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_FILL;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // frame alignment decisions for the current beat
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_we     = 1'b0;
    commit        = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      SLOT_FILL: begin
        if (accept) begin
          shadow_we = 1'b1;
          if (adc.adc_last) begin
            slot_d = '0;
            if (at_last_slot) commit = 1'b1;
            else              frame_err_set = 1'b1;
          end else if (at_last_slot) begin
            // more beats than slots: discard and wait for the frame end
            frame_err_set = 1'b1;
            slot_d        = '0;
            state_d       = RESYNC;
          end else begin
            slot_d = slot_q + SLOT_CNT_WIDTH_P'(1);
          end
        end
      end
      RESYNC: begin
        if (accept && adc.adc_last) state_d = SLOT_FILL;
      end
      default: state_d = SLOT_FILL;
    endcase
  end

  // shadow buffer collects the frame being assembled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N; s++) shadow[s] <= '0;
    end else begin
      for (int s = 0; s < N; s++)
        if (shadow_we && slot_q == SLOT_CNT_WIDTH_P'(s)) shadow[s] <= adc.adc_data;
    end
  end

  // the last slot arrives on the commit beat itself, so take it from the bus
  always_comb begin
    commit_frame = '0;
    for (int s = 0; s < N; s++)
      commit_frame[s*AW +: AW] = (s == N - 1) ? adc.adc_data : shadow[s];
  end

  // publish the whole frame atomically and count it
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_data        <= '0;
      fs_strobe      <= 1'b0;
      sr_frame_count <= '0;
    end else begin
      fs_strobe <= commit;
      if (commit) begin
        ch_data        <= commit_frame;
        sr_frame_count <= sr_frame_count + FRAME_CNT_WIDTH_P'(1);
      end
    end
  end

  // sticky framing error; a new error beats a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst)                sr_frame_err <= 1'b0;
    else if (frame_err_set) sr_frame_err <= 1'b1;
    else if (cmd_clear_err) sr_frame_err <= 1'b0;
  end

  // signed peak tracking on the published frame; clear then apply the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_peak_max <= {N{MOST_NEG}};
      sr_peak_min <= {N{MOST_POS}};
    end else begin
      for (int c = 0; c < N; c++) begin
        if (fs_strobe && cmd_clear_peak) begin
          sr_peak_max[c*AW +: AW] <= ch_data[c*AW +: AW];
          sr_peak_min[c*AW +: AW] <= ch_data[c*AW +: AW];
        end else if (fs_strobe) begin
          if ($signed(ch_data[c*AW +: AW]) > $signed(sr_peak_max[c*AW +: AW]))
            sr_peak_max[c*AW +: AW] <= ch_data[c*AW +: AW];
          if ($signed(ch_data[c*AW +: AW]) < $signed(sr_peak_min[c*AW +: AW]))
            sr_peak_min[c*AW +: AW] <= ch_data[c*AW +: AW];
        end else if (cmd_clear_peak) begin
          sr_peak_max[c*AW +: AW] <= MOST_NEG;
          sr_peak_min[c*AW +: AW] <= MOST_POS;
        end
      end
    end
  end

  // periodic IRQ timers; a period change restarts the count silently
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_OF_IRQ_P; i++) begin
        period_q[i]  <= '0;
        irq_cnt_q[i] <= '0;
        irq[i]       <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NR_OF_IRQ_P; i++) begin
        if (cr_irq_period[i*IW +: IW] != period_q[i]) begin
          period_q[i]  <= cr_irq_period[i*IW +: IW];
          irq_cnt_q[i] <= '0;
          irq[i]       <= 1'b0;
        end else if (period_q[i] == '0) begin
          irq_cnt_q[i] <= '0;
          irq[i]       <= 1'b0;
        end else if (irq_cnt_q[i] == period_q[i] - IW'(1)) begin
          irq_cnt_q[i] <= '0;
          irq[i]       <= 1'b1;
        end else begin
          irq_cnt_q[i] <= irq_cnt_q[i] + IW'(1);
          irq[i]       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dafx_adc_frame_router.sv
// Self-checking bench for dafx_adc_frame_router: a frame-level reference model
// checks the two-slot instance every cycle; a directed table, IRQ and reset
// sequences and a four-slot instance cover the corner cases.
module tb_dafx_adc_frame_router;
  localparam int AW = 24;
  localparam int N  = 2;
  localparam int N4 = 4;
  localparam int NI = 2;
  localparam int IW = 32;
  localparam int FW = 32;
  localparam logic [AW-1:0] NEG = 24'h800000;
  localparam logic [AW-1:0] POS = 24'h7FFFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            cr_enable;
  logic [NI*IW-1:0] cr_irq_period;
  logic            cmd_clear_peak;
  logic            cmd_clear_err;

  logic [N*AW-1:0] ch_data, sr_peak_max, sr_peak_min;
  logic            fs_strobe, sr_frame_err;
  logic [NI-1:0]   irq;
  logic [FW-1:0]   sr_frame_count;

  logic [N4*AW-1:0] ch_data4, peak_max4, peak_min4;
  logic             fs_strobe4, frame_err4;
  logic [NI-1:0]    irq4;
  logic [FW-1:0]    frame_count4;

  dafx_adc_frame_router_if #(.AUDIO_WIDTH_P(AW)) bus2 ();
  dafx_adc_frame_router_if #(.AUDIO_WIDTH_P(AW)) bus4 ();

  always #5 clk = ~clk;

  dafx_adc_frame_router #(.AUDIO_WIDTH_P(AW), .NR_OF_SLOTS_P(N)) u_dut (
    .clk(clk), .rst(rst), .adc(bus2), .cr_enable(cr_enable),
    .cr_irq_period(cr_irq_period), .cmd_clear_peak(cmd_clear_peak),
    .cmd_clear_err(cmd_clear_err), .ch_data(ch_data), .fs_strobe(fs_strobe),
    .irq(irq), .sr_peak_max(sr_peak_max), .sr_peak_min(sr_peak_min),
    .sr_frame_err(sr_frame_err), .sr_frame_count(sr_frame_count)
  );

  dafx_adc_frame_router #(.AUDIO_WIDTH_P(AW), .NR_OF_SLOTS_P(N4)) u_dut4 (
    .clk(clk), .rst(rst), .adc(bus4), .cr_enable(cr_enable),
    .cr_irq_period(cr_irq_period), .cmd_clear_peak(cmd_clear_peak),
    .cmd_clear_err(cmd_clear_err), .ch_data(ch_data4), .fs_strobe(fs_strobe4),
    .irq(irq4), .sr_peak_max(peak_max4), .sr_peak_min(peak_min4),
    .sr_frame_err(frame_err4), .sr_frame_count(frame_count4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (two-slot instance) ----------------
  logic [AW-1:0]        m_frame[$];
  bit                   m_resync;
  bit                   m_ready;
  logic signed [AW-1:0] m_ch  [N];
  logic signed [AW-1:0] m_max [N];
  logic signed [AW-1:0] m_min [N];
  bit                   m_fs;
  logic [FW-1:0]        m_count;
  bit                   m_err;
  logic [IW-1:0]        m_per [NI];
  int                   m_k   [NI];
  bit                   m_irq [NI];

  task automatic model_edge();
    bit new_err;
    if (rst) begin
      m_frame.delete();
      m_resync = 0; m_ready = 0; m_fs = 0; m_count = '0; m_err = 0;
      for (int c = 0; c < N; c++) begin m_ch[c] = '0; m_max[c] = NEG; m_min[c] = POS; end
      for (int i = 0; i < NI; i++) begin m_per[i] = '0; m_k[i] = 0; m_irq[i] = 0; end
      return;
    end
    for (int c = 0; c < N; c++) begin
      if (m_fs && cmd_clear_peak) begin m_max[c] = m_ch[c]; m_min[c] = m_ch[c]; end
      else if (m_fs) begin
        if (m_ch[c] > m_max[c]) m_max[c] = m_ch[c];
        if (m_ch[c] < m_min[c]) m_min[c] = m_ch[c];
      end else if (cmd_clear_peak) begin m_max[c] = NEG; m_min[c] = POS; end
    end
    m_fs = 0;
    new_err = 0;
    if (bus2.adc_valid && m_ready) begin
      if (m_resync) begin
        if (bus2.adc_last) m_resync = 0;
      end else begin
        m_frame.push_back(bus2.adc_data);
        if (bus2.adc_last) begin
          if (m_frame.size() == N) begin
            for (int c = 0; c < N; c++) m_ch[c] = m_frame[c];
            m_fs = 1;
            m_count = m_count + 1;
          end else new_err = 1;
          m_frame.delete();
        end else if (m_frame.size() == N) begin
          new_err = 1;
          m_resync = 1;
          m_frame.delete();
        end
      end
    end
    if (new_err) m_err = 1;
    else if (cmd_clear_err) m_err = 0;
    for (int i = 0; i < NI; i++) begin
      if (cr_irq_period[i*IW +: IW] != m_per[i]) begin
        m_per[i] = cr_irq_period[i*IW +: IW]; m_k[i] = 0; m_irq[i] = 0;
      end else begin
        m_k[i]++;
        m_irq[i] = (m_per[i] != 0) && ((m_k[i] % int'(m_per[i])) == 0);
      end
    end
    m_ready = cr_enable;
  endtask

  task automatic check_all();
    logic [N*AW-1:0] e_ch, e_max, e_min;
    logic [NI-1:0]   e_irq;
    for (int c = 0; c < N; c++) begin
      e_ch[c*AW +: AW] = m_ch[c]; e_max[c*AW +: AW] = m_max[c]; e_min[c*AW +: AW] = m_min[c];
    end
    for (int i = 0; i < NI; i++) e_irq[i] = m_irq[i];
    chk("adc_ready",   bus2.adc_ready, m_ready);
    chk("fs_strobe",   fs_strobe, m_fs);
    chk("ch_data",     ch_data, e_ch);
    chk("frame_count", sr_frame_count, m_count);
    chk("frame_err",   sr_frame_err, m_err);
    chk("peak_max",    sr_peak_max, e_max);
    chk("peak_min",    sr_peak_min, e_min);
    chk("irq",         irq, e_irq);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit l, input logic [AW-1:0] d);
    bus2.adc_valid = v; bus2.adc_last = l; bus2.adc_data = d;
  endtask

  task automatic drive4(input bit v, input bit l, input logic [AW-1:0] d);
    bus4.adc_valid = v; bus4.adc_last = l; bus4.adc_data = d;
  endtask

  typedef struct {
    bit v; bit l; logic [AW-1:0] d; bit cp; bit ce;
    bit e_fs; logic [AW-1:0] e_ch0; logic [AW-1:0] e_ch1; bit e_err; int e_cnt;
    logic [AW-1:0] e_pmax0; logic [AW-1:0] e_pmin0; logic [AW-1:0] e_pmax1;
  } vec_t;

  vec_t tbl [16];
  int   cnt0, cnt1;
  bit   seen_fs4;

  initial begin
    tbl[0]  = '{1,0,24'h000100,0,0, 0,24'h0,     24'h0,     0,0, NEG,       POS,       NEG};
    tbl[1]  = '{1,1,24'h7FFFFF,0,0, 1,24'h000100,24'h7FFFFF,0,1, NEG,       POS,       NEG};
    tbl[2]  = '{0,0,24'h0,     0,0, 0,24'h000100,24'h7FFFFF,0,1, 24'h000100,24'h000100,24'h7FFFFF};
    tbl[3]  = '{1,1,24'h123456,0,0, 0,24'h000100,24'h7FFFFF,1,1, 24'h000100,24'h000100,24'h7FFFFF};
    tbl[4]  = '{1,0,24'hFFFFFB,0,0, 0,24'h000100,24'h7FFFFF,1,1, 24'h000100,24'h000100,24'h7FFFFF};
    tbl[5]  = '{1,1,24'h000010,0,0, 1,24'hFFFFFB,24'h000010,1,2, 24'h000100,24'h000100,24'h7FFFFF};
    tbl[6]  = '{0,0,24'h0,     0,1, 0,24'hFFFFFB,24'h000010,0,2, 24'h000100,24'hFFFFFB,24'h7FFFFF};
    tbl[7]  = '{1,0,24'h000003,0,0, 0,24'hFFFFFB,24'h000010,0,2, 24'h000100,24'hFFFFFB,24'h7FFFFF};
    tbl[8]  = '{1,1,24'h000020,0,0, 1,24'h000003,24'h000020,0,3, 24'h000100,24'hFFFFFB,24'h7FFFFF};
    tbl[9]  = '{0,0,24'h0,     0,0, 0,24'h000003,24'h000020,0,3, 24'h000100,24'hFFFFFB,24'h7FFFFF};
    tbl[10] = '{1,0,24'hFFFFF9,0,0, 0,24'h000003,24'h000020,0,3, 24'h000100,24'hFFFFFB,24'h7FFFFF};
    tbl[11] = '{1,1,24'h000001,0,0, 1,24'hFFFFF9,24'h000001,0,4, 24'h000100,24'hFFFFFB,24'h7FFFFF};
    tbl[12] = '{0,0,24'h0,     1,0, 0,24'hFFFFF9,24'h000001,0,4, 24'hFFFFF9,24'hFFFFF9,24'h000001};
    tbl[13] = '{0,0,24'h0,     1,0, 0,24'hFFFFF9,24'h000001,0,4, NEG,       POS,       NEG};
    tbl[14] = '{1,1,24'h000005,0,1, 0,24'hFFFFF9,24'h000001,1,4, NEG,       POS,       NEG};
    tbl[15] = '{0,0,24'h0,     0,1, 0,24'hFFFFF9,24'h000001,0,4, NEG,       POS,       NEG};

    rst = 1; cr_enable = 1; cr_irq_period = '0; cmd_clear_peak = 0; cmd_clear_err = 0;
    drive(0, 0, '0); drive4(0, 0, '0);

    // reset, then ready rises one cycle after release
    step(); step();
    chk("reset_ready", bus2.adc_ready, 1'b0);
    chk("reset_pmax", sr_peak_max, {N{NEG}});
    chk("reset_pmin", sr_peak_min, {N{POS}});
    rst = 0;
    step();

    // directed table: basic frame, short frame, error clear, peaks
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].d);
      cmd_clear_peak = tbl[i].cp; cmd_clear_err = tbl[i].ce;
      step();
      chk($sformatf("tbl%0d_fs", i),    fs_strobe, tbl[i].e_fs);
      chk($sformatf("tbl%0d_ch", i),    ch_data, {tbl[i].e_ch1, tbl[i].e_ch0});
      chk($sformatf("tbl%0d_err", i),   sr_frame_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_cnt", i),   sr_frame_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_pmax0", i), sr_peak_max[AW-1:0], tbl[i].e_pmax0);
      chk($sformatf("tbl%0d_pmin0", i), sr_peak_min[AW-1:0], tbl[i].e_pmin0);
      chk($sformatf("tbl%0d_pmax1", i), sr_peak_max[2*AW-1:AW], tbl[i].e_pmax1);
    end
    drive(0, 0, '0); cmd_clear_peak = 0; cmd_clear_err = 0;

    // backpressure: ready drops one cycle after cr_enable, beats ignored
    cr_enable = 0;
    drive(1, 0, 24'h0ABCDE);
    step();
    chk("bp_ready_off", bus2.adc_ready, 1'b0);
    drive(1, 1, 24'h0BCDEF);
    step(); step();
    chk("bp_no_commit", sr_frame_count, 32'd4);
    drive(0, 0, '0);
    cr_enable = 1;
    step();
    chk("bp_ready_on", bus2.adc_ready, 1'b1);

    // reset mid-frame discards the partial frame
    drive(1, 0, 24'hAAAAAA);
    step();
    drive(0, 0, '0); rst = 1;
    step();
    rst = 0;
    step();
    drive(1, 0, 24'h111111); step();
    drive(1, 1, 24'h222222); step();
    drive(0, 0, '0);
    chk("rst_mid_fs", fs_strobe, 1'b1);
    chk("rst_mid_cnt", sr_frame_count, 32'd1);
    chk("rst_mid_ch", ch_data, {24'h222222, 24'h111111});

    // four-slot instance: long frame of 6 beats, then a good 4-beat frame
    seen_fs4 = 0;
    for (int k = 1; k <= 6; k++) begin
      drive4(1, k == 6, AW'(k * 16));
      step();
      if (fs_strobe4) seen_fs4 = 1;
    end
    drive4(0, 0, '0);
    step();
    if (fs_strobe4) seen_fs4 = 1;
    chk("long_no_fs", seen_fs4, 1'b0);
    chk("long_err", frame_err4, 1'b1);
    chk("long_ch", ch_data4, '0);
    for (int k = 1; k <= 4; k++) begin
      drive4(1, k == 4, AW'(k));
      step();
    end
    drive4(0, 0, '0);
    chk("long_next_fs", fs_strobe4, 1'b1);
    chk("long_next_ch", ch_data4, {24'd4, 24'd3, 24'd2, 24'd1});
    chk("long_next_cnt", frame_count4, 32'd1);

    // IRQ: period 10 on timer 0 and period 1 on timer 1
    cr_irq_period = {32'd1, 32'd10};
    step();
    chk("irq_change_quiet", irq, 2'b00);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (irq[0]) cnt0++;
      if (irq[1]) cnt1++;
    end
    chk("irq0_p10_count", cnt0, 4);
    chk("irq1_p1_count", cnt1, 40);
    // let timer 0 run 3 cycles into a new count, then change its period
    step(); step(); step();
    cr_irq_period[31:0] = 32'd4;
    step();
    chk("irq0_change_quiet", irq[0], 1'b0);
    cnt0 = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (irq[0]) cnt0++;
      if (k == 3) chk("irq0_p4_not_early", irq[0], 1'b0);
      if (k == 4) chk("irq0_p4_first", irq[0], 1'b1);
    end
    chk("irq0_p4_count", cnt0, 3);
    cr_irq_period = '0;
    cnt0 = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (irq != 0) cnt0++;
    end
    chk("irq_off_count", cnt0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 499) == 0);
      cr_enable      = ($urandom_range(0, 19) != 0);
      cmd_clear_peak = ($urandom_range(0, 39) == 0);
      cmd_clear_err  = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom));
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          case ($urandom_range(0, 5))
            0: cr_irq_period[i*IW +: IW] = 32'd0;
            1: cr_irq_period[i*IW +: IW] = 32'd1;
            2: cr_irq_period[i*IW +: IW] = 32'd2;
            3: cr_irq_period[i*IW +: IW] = 32'd3;
            4: cr_irq_period[i*IW +: IW] = 32'd7;
            default: cr_irq_period[i*IW +: IW] = 32'($urandom_range(1, 50));
          endcase
        end
      end
      step();
    end
    rst = 0; drive(0, 0, '0); cmd_clear_peak = 0; cmd_clear_err = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
